// File: rtl/pipe_field_pkg.sv
// Shared types and constants for the pipe_field obstacle engine.
// Holds the game state encoding, coordinate widths and the gap LFSR seed/taps/step.
package pipe_field_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CRASH = 2'd2
    } state_t;

    localparam int X_W_DEFAULT = 11;
    localparam int Y_W         = 10;
    localparam int SPEED_W     = 3;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps 8,6,5,4 of a maximal-length 8-bit Fibonacci LFSR.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pipe_field_if.sv
// Game-control and pipe-geometry bundle between the frame timing, pipe_field and the pixel generator.
// The master drives the per-frame controls; the slave (pipe_field) returns the pipe layout and game status.
interface pipe_field_if
    import pipe_field_pkg::*;
#(
    parameter int NUM_PIPES = 3,
    parameter int X_W       = X_W_DEFAULT
);
    logic                       frame_tick;
    logic                       start;
    logic [SPEED_W-1:0]         speed;
    logic [Y_W-1:0]             bird_y;
    logic [NUM_PIPES*X_W-1:0]   pipe_x;
    logic [NUM_PIPES*Y_W-1:0]   pipe_gap;
    logic                       running;
    logic                       crashed;
    logic                       score_pulse;
    logic [7:0]                 score;

    modport master (
        output frame_tick, start, speed, bird_y,
        input  pipe_x, pipe_gap, running, crashed, score_pulse, score
    );

    modport slave (
        input  frame_tick, start, speed, bird_y,
        output pipe_x, pipe_gap, running, crashed, score_pulse, score
    );
endinterface

// File: rtl/pipe_field_channel.sv
// One pipe of the field: holds its left edge and gap row, computes the scrolled/respawned position,
// and flags bird overlap and the frame on which the pipe's right edge passes the bird.
module pipe_channel
    import pipe_field_pkg::*;
#(
    parameter int X_W       = X_W_DEFAULT,
    parameter int NUM_PIPES = 3,
    parameter int SPACING   = 220,
    parameter int PIPE_W    = 40,
    parameter int GAP_H     = 120,
    parameter int BIRD_X    = 100,
    parameter int BIRD_SIZE = 16,
    parameter int INIT_X    = 640,
    parameter int INIT_GAP  = 40
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_init,
    input  logic               move_en,
    input  logic [SPEED_W-1:0] speed,
    input  logic [Y_W-1:0]     bird_y,
    input  logic [Y_W-1:0]     new_gap,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     gap,
    output logic               hit,
    output logic               pass,
    output logic               respawn
);
    localparam int XE = X_W + 1;
    localparam int YE = Y_W + 1;

    logic [XE-1:0] x_ext;
    logic [XE-1:0] spd;
    logic [XE-1:0] x_next;
    logic          h_overlap;
    logic          v_outside;

    assign x_ext   = {1'b0, x};
    assign spd     = XE'(speed);
    assign respawn = x_ext < spd;
    // Respawn adds the full field pitch so spacing to the neighbouring pipes stays exact.
    assign x_next  = respawn ? x_ext + XE'(NUM_PIPES * SPACING) - spd : x_ext - spd;

    assign h_overlap = (x_ext < XE'(BIRD_X + BIRD_SIZE)) && (x_ext + XE'(PIPE_W) > XE'(BIRD_X));
    assign v_outside = (bird_y < gap) ||
                       ({1'b0, bird_y} + YE'(BIRD_SIZE) > {1'b0, gap} + YE'(GAP_H));
    assign hit  = h_overlap && v_outside;
    assign pass = (x_ext + XE'(PIPE_W) >= XE'(BIRD_X)) && (x_next + XE'(PIPE_W) < XE'(BIRD_X));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x   <= X_W'(INIT_X);
            gap <= Y_W'(INIT_GAP);
        end else if (load_init) begin
            x   <= X_W'(INIT_X);
            gap <= Y_W'(INIT_GAP);
        end else if (move_en) begin
            x <= x_next[X_W-1:0];
            if (respawn) gap <= new_gap;
        end
    end

endmodule

// File: rtl/pipe_field.sv
// Flappy-bird obstacle engine: N scrolling pipes, game FSM, collision and score tracking.
// Define PIPE_FIELD_LFSR_EN to draw respawn gaps from an 8-bit LFSR instead of the 2-bit cycling counter.
module pipe_field
    import pipe_field_pkg::*;
#(
    parameter int NUM_PIPES = 3,
    parameter int X_W       = X_W_DEFAULT,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int PIPE_W    = 40,
    parameter int GAP_H     = 120,
    parameter int GAP_MIN   = 40,
    parameter int SPACING   = 220,
    parameter int BIRD_X    = 100,
    parameter int BIRD_SIZE = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    pipe_field_if.slave  bus
);
    localparam int YE = Y_W + 1;

    state_t               state;
    logic                 running_q;
    logic                 crashed_q;
    logic                 pulse_q;
    logic [7:0]           score_q;

    logic [NUM_PIPES-1:0] hit;
    logic [NUM_PIPES-1:0] pass;
    logic [NUM_PIPES-1:0] respawn;
    logic [X_W-1:0]       ch_x   [NUM_PIPES];
    logic [Y_W-1:0]       ch_gap [NUM_PIPES];
    logic [Y_W-1:0]       new_gap;

    logic                 floor_hit;
    logic                 crash_now;
    logic                 move_en;
    logic                 load_init;
    logic [8:0]           pass_cnt;
    logic [9:0]           score_sum;
    logic [7:0]           score_sat;

    assign floor_hit = ({1'b0, bus.bird_y} + YE'(BIRD_SIZE)) > YE'(V_RES);
    assign crash_now = floor_hit || (|hit);
    assign move_en   = (state == S_RUN) && bus.frame_tick && !crash_now;
    assign load_init = bus.start && (state != S_RUN);

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
        pipe_channel #(
            .X_W       (X_W),
            .NUM_PIPES (NUM_PIPES),
            .SPACING   (SPACING),
            .PIPE_W    (PIPE_W),
            .GAP_H     (GAP_H),
            .BIRD_X    (BIRD_X),
            .BIRD_SIZE (BIRD_SIZE),
            .INIT_X    (H_RES + i * SPACING),
            .INIT_GAP  (GAP_MIN + 64 * (i % 4))
        ) u_channel (
            .clk       (clk),
            .reset_n   (reset_n),
            .load_init (load_init),
            .move_en   (move_en),
            .speed     (bus.speed),
            .bird_y    (bus.bird_y),
            .new_gap   (new_gap),
            .x         (ch_x[i]),
            .gap       (ch_gap[i]),
            .hit       (hit[i]),
            .pass      (pass[i]),
            .respawn   (respawn[i])
        );
        assign bus.pipe_x[i*X_W +: X_W]   = ch_x[i];
        assign bus.pipe_gap[i*Y_W +: Y_W] = ch_gap[i];
    end

    // Pipe pitch exceeds the frame step, so at most one pipe respawns per tick and a single gap value suffices.
`ifdef PIPE_FIELD_LFSR_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                lfsr <= LFSR_SEED;
        else if (move_en && |respawn) lfsr <= lfsr_step(lfsr);
    end

    assign new_gap = Y_W'(GAP_MIN) + Y_W'(lfsr);
`else
    localparam logic [1:0] K_INIT = 2'(NUM_PIPES % 4);
    logic [1:0] gap_k;

    // The counter starts where the initial layout left off, so the gap sequence keeps cycling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 gap_k <= K_INIT;
        else if (load_init)           gap_k <= K_INIT;
        else if (move_en && |respawn) gap_k <= gap_k + 2'd1;
    end

    assign new_gap = Y_W'(GAP_MIN) + Y_W'({gap_k, 6'd0});
`endif

    // NOTE: every always_comb output gets a default before the loop, so no latch can be inferred.
    always_comb begin
        pass_cnt = '0;
        for (int i = 0; i < NUM_PIPES; i++) pass_cnt = pass_cnt + 9'(pass[i]);
    end

    assign score_sum = 10'(score_q) + 10'(pass_cnt);
    assign score_sat = (score_sum > 10'd255) ? 8'hFF : score_sum[7:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            running_q <= 1'b0;
            crashed_q <= 1'b0;
            pulse_q   <= 1'b0;
            score_q   <= '0;
        end else begin
            pulse_q <= 1'b0;
            unique case (state)
                S_IDLE, S_CRASH: begin
                    if (bus.start) begin
                        state     <= S_RUN;
                        running_q <= 1'b1;
                        crashed_q <= 1'b0;
                        score_q   <= '0;
                    end
                end
                S_RUN: begin
                    if (bus.frame_tick) begin
                        if (crash_now) begin
                            state     <= S_CRASH;
                            running_q <= 1'b0;
                            crashed_q <= 1'b1;
                        end else if (|pass) begin
                            score_q <= score_sat;
                            pulse_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    running_q <= 1'b0;
                    crashed_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.running     = running_q;
    assign bus.crashed     = crashed_q;
    assign bus.score_pulse = pulse_q;
    assign bus.score       = score_q;

endmodule

// File: tb/tb_pipe_field.sv
// Self-checking bench for pipe_field: directed game scenarios plus randomized play,
// all compared each cycle against a plain-integer model of the game rules.
module tb_pipe_field;
    localparam int N         = 3;
    localparam int XW        = 11;
    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int PIPE_W    = 40;
    localparam int GAP_H     = 120;
    localparam int GAP_MIN   = 40;
    localparam int SPACING   = 220;
    localparam int BIRD_X    = 100;
    localparam int BIRD_SIZE = 16;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_CRASH = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pipe_field_if #(.NUM_PIPES(N), .X_W(XW)) bus ();

    pipe_field #(.NUM_PIPES(N), .X_W(XW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference game state
    int mx [N];
    int mg [N];
    int m_state;
    int m_score;
    int m_pulse;
    int m_k;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void m_layout();
        for (int i = 0; i < N; i++) begin
            mx[i] = H_RES + i * SPACING;
            mg[i] = GAP_MIN + 64 * (i % 4);
        end
        m_k = N % 4;
    endfunction

    function automatic void m_reset();
        m_layout();
        m_state = M_IDLE;
        m_score = 0;
        m_pulse = 0;
    endfunction

    function automatic bit overlaps(int x);
        return (x < BIRD_X + BIRD_SIZE) && (x + PIPE_W > BIRD_X);
    endfunction

    function automatic void m_step(bit tick, bit st, int spd, int by);
        bit crash;
        int passes;
        int nx;
        m_pulse = 0;
        if (m_state != M_RUN) begin
            if (st) begin
                m_layout();
                m_score = 0;
                m_state = M_RUN;
            end
        end else if (tick) begin
            crash = (by + BIRD_SIZE > V_RES);
            for (int i = 0; i < N; i++)
                if (overlaps(mx[i]) && (by < mg[i] || by + BIRD_SIZE > mg[i] + GAP_H)) crash = 1;
            if (crash) begin
                m_state = M_CRASH;
            end else begin
                passes = 0;
                for (int i = 0; i < N; i++) begin
                    if (mx[i] < spd) begin
                        nx = mx[i] + N * SPACING - spd;
                        mg[i] = GAP_MIN + 64 * m_k;
                        m_k = (m_k + 1) % 4;
                    end else begin
                        nx = mx[i] - spd;
                    end
                    if (mx[i] + PIPE_W >= BIRD_X && nx + PIPE_W < BIRD_X) passes++;
                    mx[i] = nx;
                end
                if (passes > 0) begin
                    m_pulse = 1;
                    m_score = (m_score + passes > 255) ? 255 : m_score + passes;
                end
            end
        end
    endfunction

    // Bird row centred in whichever pipe currently shares its column
    function automatic int safe_by();
        int r = 200;
        for (int i = 0; i < N; i++)
            if (overlaps(mx[i])) r = mg[i] + (GAP_H - BIRD_SIZE) / 2;
        return r;
    endfunction

    task automatic compare_all();
        logic [N*XW-1:0] exp_px;
        logic [N*10-1:0] exp_pg;
        for (int i = 0; i < N; i++) begin
            exp_px[i*XW +: XW] = XW'(mx[i]);
            exp_pg[i*10 +: 10] = 10'(mg[i]);
        end
        check("pipe_x", bus.pipe_x, exp_px);
        check("pipe_gap", bus.pipe_gap, exp_pg);
        check("running", bus.running, (m_state == M_RUN) ? 1 : 0);
        check("crashed", bus.crashed, (m_state == M_CRASH) ? 1 : 0);
        check("score_pulse", bus.score_pulse, m_pulse);
        check("score", bus.score, m_score);
    endtask

    task automatic cycle(input bit tick, input bit st, input int spd, input int by);
        @(negedge clk);
        bus.frame_tick = tick;
        bus.start      = st;
        bus.speed      = 3'(spd);
        bus.bird_y     = 10'(by);
        m_step(tick, st, spd, by);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        int iter;
        bit seen;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.speed      = '0;
        bus.bird_y     = '0;
        m_reset();
        #12;
        compare_all();
        check("reset_x0", bus.pipe_x[XW-1:0], 640);
        @(negedge clk);
        reset_n = 1'b1;

        // Tick in IDLE is ignored, then start
        cycle(1, 0, 2, 200);
        cycle(0, 1, 2, 200);
        check("start_running", bus.running, 1);
        cycle(1, 0, 2, safe_by());
        check("x0_first_tick", bus.pipe_x[XW-1:0], 638);
        check("score_first_tick", bus.score, 0);

        // Walk pipe 0 to x=90, then fly above its gap
        iter = 0;
        while (mx[0] != 90 && iter < 400) begin
            cycle(1, 0, 2, safe_by());
            iter++;
        end
        check("reach_x90", (mx[0] == 90) ? 1 : 0, 1);
        cycle(1, 0, 2, 10);
        check("crash_flag", bus.crashed, 1);
        check("crash_no_move", bus.pipe_x[XW-1:0], 90);
        for (int i = 0; i < 3; i++) cycle(1, 0, 5, 10);
        check("frozen_x0", bus.pipe_x[XW-1:0], 90);

        // Restart from CRASH with a coincident tick: layout reloaded, no move
        cycle(1, 1, 2, 200);
        check("restart_x0", bus.pipe_x[XW-1:0], 640);
        check("restart_score", bus.score, 0);

        // Speed 3 until pipe 0 sits at x=1, watching for the first pass
        iter = 0;
        seen = 0;
        while (mx[0] != 1 && iter < 400) begin
            cycle(1, 0, 3, safe_by());
            if (m_pulse && !seen) begin
                seen = 1;
                check("first_pass_score", bus.score, 1);
            end
            iter++;
        end
        check("reach_x1", (mx[0] == 1) ? 1 : 0, 1);
        cycle(1, 0, 3, safe_by());
        check("respawn_x0", bus.pipe_x[XW-1:0], 658);
        check("respawn_gap0", bus.pipe_gap[9:0], GAP_MIN + 64 * 3);

        // Long safe run at top speed to saturate the score; starts in RUN are ignored
        iter = 0;
        while (m_score < 255 && iter < 12000) begin
            cycle(1, (iter % 97) == 5, 7, safe_by());
            iter++;
        end
        check("reach_255", m_score, 255);
        check("score_255", bus.score, 255);
        iter = 0;
        seen = 0;
        while (!seen && iter < 200) begin
            cycle(1, 0, 7, safe_by());
            if (m_pulse) begin
                seen = 1;
                check("sat_pulse", bus.score_pulse, 1);
                check("sat_score", bus.score, 255);
            end
            iter++;
        end
        check("sat_pass_seen", seen, 1);

        // Randomized play
        for (int n = 0; n < 3000; n++) begin
            int by;
            by = ($urandom_range(0, 9) < 7) ? safe_by() : int'($urandom_range(0, 479));
            cycle(bit'($urandom_range(0, 1)), $urandom_range(0, 19) == 0,
                  int'($urandom_range(0, 7)), by);
        end

        // Asynchronous reset in the middle of a running game
        cycle(0, 1, 3, 200);
        for (int i = 0; i < 20; i++) cycle(1, 0, 3, safe_by());
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        m_reset();
        compare_all();
        check("async_rst_running", bus.running, 0);
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        reset_n = 1'b1;
        cycle(1, 0, 3, 200);
        check("post_rst_tick_ignored", bus.pipe_x[XW-1:0], 640);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
